// File: rtl/tmds_decoder.sv
// TMDS receive channel: finds word alignment via bitslip requests on control tokens, then
// decodes each 10-bit word back to video data, control data and data-enable.
module tmds_decoder #(
   parameter int unsigned LOCK_COUNT     = 8,
   parameter int unsigned SEARCH_TIMEOUT = 2048,
   parameter int unsigned SLIP_SETTLE    = 4,
   parameter int unsigned LOSS_TIMEOUT   = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] tmds_in,
   output logic       bitslip,
   output logic       locked,
   output logic [7:0] VD,
   output logic [1:0] CD,
   output logic       VDE
);

   localparam int unsigned RunW    = $clog2(LOCK_COUNT) + 1;
   localparam int unsigned SearchW = $clog2(SEARCH_TIMEOUT) + 1;
   localparam int unsigned SettleW = $clog2(SLIP_SETTLE) + 1;
   localparam int unsigned IdleW   = $clog2(LOSS_TIMEOUT) + 1;

   localparam logic [RunW-1:0]    RunMax    = RunW'(LOCK_COUNT - 1);
   localparam logic [SearchW-1:0] SearchMax = SearchW'(SEARCH_TIMEOUT - 1);
   localparam logic [SettleW-1:0] SettleMax = SettleW'(SLIP_SETTLE - 1);
   localparam logic [IdleW-1:0]   IdleMax   = IdleW'(LOSS_TIMEOUT - 1);

   localparam logic [1:0] StSearch = 2'd0;
   localparam logic [1:0] StSlip   = 2'd1;
   localparam logic [1:0] StSettle = 2'd2;
   localparam logic [1:0] StLocked = 2'd3;

   logic [9:0]         w_q;
   logic [1:0]         state_q, state_d;
   logic [RunW-1:0]    run_q, run_d;
   logic [SearchW-1:0] search_q, search_d;
   logic [SettleW-1:0] settle_q, settle_d;
   logic [IdleW-1:0]   idle_q, idle_d;
   logic [7:0]         vd_q;
   logic [1:0]         cd_q;
   logic               vde_q;

   logic       is_ctrl;
   logic [1:0] tok_cd;
   logic [7:0] d;
   logic [7:0] dec;

   always_comb begin
      is_ctrl = 1'b1;
      tok_cd  = 2'b00;
      case (w_q)
         10'b1101010100: tok_cd = 2'b00;
         10'b0010101011: tok_cd = 2'b01;
         10'b0101010100: tok_cd = 2'b10;
         10'b1010101011: tok_cd = 2'b11;
         default:        is_ctrl = 1'b0;
      endcase
   end

   // Undo the optional inversion, then the XOR/XNOR transition chain.
   always_comb begin
      d      = w_q[9] ? ~w_q[7:0] : w_q[7:0];
      dec    = '0;
      dec[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = w_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
   end

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      search_d = search_q;
      settle_d = settle_q;
      idle_d   = idle_q;
      unique case (state_q)
         StSearch: begin
            run_d    = is_ctrl ? ((run_q == RunMax) ? run_q : run_q + 1'b1) : '0;
            search_d = (search_q == SearchMax) ? search_q : search_q + 1'b1;
            // Lock takes priority over a simultaneous timeout.
            if (is_ctrl && run_q == RunMax) begin
               state_d  = StLocked;
               run_d    = '0;
               search_d = '0;
               idle_d   = '0;
            end else if (search_q == SearchMax) begin
               state_d  = StSlip;
               run_d    = '0;
               search_d = '0;
            end
         end
         StSlip: begin
            state_d  = StSettle;
            settle_d = '0;
            run_d    = '0;
            search_d = '0;
         end
         StSettle: begin
            if (settle_q == SettleMax) begin
               state_d  = StSearch;
               settle_d = '0;
               run_d    = '0;
               search_d = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         StLocked: begin
            if (is_ctrl) begin
               idle_d = '0;
            end else if (idle_q == IdleMax) begin
               state_d  = StSearch;
               idle_d   = '0;
               run_d    = '0;
               search_d = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: state_d = StSearch;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q      <= '0;
         state_q  <= StSearch;
         run_q    <= '0;
         search_q <= '0;
         settle_q <= '0;
         idle_q   <= '0;
      end else begin
         w_q      <= tmds_in;
         state_q  <= state_d;
         run_q    <= run_d;
         search_q <= search_d;
         settle_q <= settle_d;
         idle_q   <= idle_d;
      end
   end

   // Output gating uses the lock state current while w_q is decoded, not the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vd_q  <= '0;
         cd_q  <= '0;
         vde_q <= 1'b0;
      end else if (state_q == StLocked) begin
         if (is_ctrl) begin
            vde_q <= 1'b0;
            cd_q  <= tok_cd;
            vd_q  <= '0;
         end else begin
            vde_q <= 1'b1;
            vd_q  <= dec;
         end
      end else begin
         vde_q <= 1'b0;
         vd_q  <= '0;
         cd_q  <= '0;
      end
   end

   assign bitslip = (state_q == StSlip);
   assign locked  = (state_q == StLocked);
   assign VD      = vd_q;
   assign CD      = cd_q;
   assign VDE     = vde_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: vector table plus 2-deep output scoreboard,
// with an independent TMDS encoder model and a rotating deserializer model.
module tb_tmds_decoder;

   localparam logic [9:0] TOK0 = 10'b1101010100;
   localparam logic [9:0] TOK1 = 10'b0010101011;
   localparam logic [9:0] TOK2 = 10'b0101010100;
   localparam logic [9:0] TOK3 = 10'b1010101011;
   localparam int SLIP_PERIOD = 2048 + 1 + 4;

   typedef struct {
      logic [9:0] word;
      logic       vde;
      logic [1:0] cd;
      logic [7:0] vd;
   } vec_t;

   typedef struct {
      logic       vde;
      logic [1:0] cd;
      logic [7:0] vd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] tmds_in = '0;
   logic       bitslip;
   logic       locked;
   logic [7:0] VD;
   logic [1:0] CD;
   logic       VDE;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   vec_t vt[$];

   tmds_decoder dut (
      .clk    (clk),
      .rst    (rst),
      .tmds_in(tmds_in),
      .bitslip(bitslip),
      .locked (locked),
      .VD     (VD),
      .CD     (CD),
      .VDE    (VDE)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // DVI reference encoder with running disparity.
   task automatic encode(input logic [7:0] din, input int cnt_in, output logic [9:0] q,
                         output int cnt_out);
      logic [8:0] qm;
      int n1, n1q, n0q;
      n1 = $countones(din);
      qm[0] = din[0];
      if (n1 > 4 || (n1 == 4 && din[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ din[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ din[i];
         qm[8] = 1'b1;
      end
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (cnt_in == 0 || n1q == n0q) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         cnt_out = qm[8] ? cnt_in + n1q - n0q : cnt_in + n0q - n1q;
      end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         cnt_out = cnt_in + 2 * int'(qm[8]) + n0q - n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         cnt_out = cnt_in - 2 * int'(~qm[8]) + n1q - n0q;
      end
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] v, input int n);
      logic [9:0] r;
      r = v;
      for (int k = 0; k < n; k++) r = {r[8:0], r[9]};
      return r;
   endfunction

   // One call per cycle: retire the entry driven two cycles ago, then drive and push.
   task automatic drive(input logic [9:0] word, input logic vde, input logic [1:0] cd,
                        input logic [7:0] vd);
      exp_t e;
      @(negedge clk);
      if (sb_q.size() == 2) begin
         e = sb_q.pop_front();
         check("sb_out", {21'b0, VDE, CD, VD}, {21'b0, e.vde, e.cd, e.vd});
      end
      tmds_in = word;
      e.vde = vde;
      e.cd  = cd;
      e.vd  = vd;
      sb_q.push_back(e);
   endtask

   task automatic reset_check(input string name);
      #1 rst = 1'b1;
      #1 check(name, {20'b0, bitslip, locked, VDE, CD, VD}, 32'h0);
      sb_q.delete();
      tmds_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic lock_seq(input logic [9:0] tok, input logic [1:0] cd);
      logic bs_seen;
      bs_seen = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) drive(tok, 1'b0, 2'b00, 8'h00);
         else        drive(tok, 1'b0, cd, 8'h00);
         if (bitslip) bs_seen = 1'b1;
         if (k == 9)  check("lock_early", {31'b0, locked}, 32'd0);
         if (k == 10) check("lock_set", {31'b0, locked}, 32'd1);
      end
      check("lock_no_slip", {31'b0, bs_seen}, 32'd0);
   endtask

   task automatic count_to_slip(output int n);
      n = -1;
      for (int k = 1; k <= 3000; k++) begin
         drive(10'h000, 1'b0, 2'b00, 8'h00);
         if (bitslip) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      logic [7:0] bytes [4];
      int         disp [3];
      logic [9:0] q;
      int         rd, dummy, n, c, phase, pulses, last_p;
      logic [7:0] b;

      bytes = '{8'h00, 8'hFF, 8'h55, 8'h10};
      disp  = '{0, 4, -4};
      vt.push_back('{TOK1, 1'b0, 2'b01, 8'h00});
      vt.push_back('{TOK2, 1'b0, 2'b10, 8'h00});
      vt.push_back('{TOK3, 1'b0, 2'b11, 8'h00});
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) begin
            encode(bytes[i], disp[j], q, dummy);
            vt.push_back('{q, 1'b1, 2'b11, bytes[i]});
         end
      end

      // Reset values and initial lock on TOK0.
      #2;
      reset_check("reset_outputs");
      lock_seq(TOK0, 2'b00);

      // Tokens and data at fixed disparity states.
      foreach (vt[i]) drive(vt[i].word, vt[i].vde, vt[i].cd, vt[i].vd);

      // Full byte sweep through running-disparity encoder; CD holds 11.
      rd = 0;
      for (int i = 0; i < 256; i++) begin
         encode(i[7:0], rd, q, rd);
         drive(q, 1'b1, 2'b11, i[7:0]);
      end

      // Keep-alive token at idle count 4095, then loss of lock after 4096 data words.
      drive(TOK3, 1'b0, 2'b11, 8'h00);
      for (int i = 0; i < 4095; i++) begin
         b = i[7:0];
         encode(b, rd, q, rd);
         drive(q, 1'b1, 2'b11, b);
      end
      drive(TOK2, 1'b0, 2'b10, 8'h00);
      for (int i = 0; i < 4100; i++) begin
         b = 8'(i * 7);
         encode(b, rd, q, rd);
         if (i < 4096) drive(q, 1'b1, 2'b10, b);
         else          drive(q, 1'b0, 2'b00, 8'h00);
         if (i == 1)    check("keep_lock", {31'b0, locked}, 32'd1);
         if (i == 4096) check("loss_late", {31'b0, locked}, 32'd1);
         if (i == 4097) check("loss_drop", {31'b0, locked}, 32'd0);
      end
      lock_seq(TOK1, 2'b01);

      // Asynchronous reset while LOCKED with data on the outputs.
      drive(TOK3, 1'b0, 2'b11, 8'h00);
      for (int i = 0; i < 4; i++) begin
         encode(8'hA5, rd, q, rd);
         drive(q, 1'b1, 2'b11, 8'hA5);
      end
      check("pre_rst_locked", {20'b0, bitslip, locked, VDE, CD, VD}, {20'b0, 3'b011, 2'b11, 8'hA5});
      reset_check("rst_in_locked");
      lock_seq(TOK0, 2'b00);

      // Search timeout, then asynchronous reset during SETTLE.
      reset_check("rst_plain");
      count_to_slip(n);
      check("first_slip_cycle", n, 32'd2048);
      drive(10'h000, 1'b0, 2'b00, 8'h00);
      check("slip_one_cycle", {31'b0, bitslip}, 32'd0);
      drive(10'h000, 1'b0, 2'b00, 8'h00);
      reset_check("rst_in_settle");
      count_to_slip(n);
      check("slip_after_settle_rst", n, 32'd2048);

      // Alignment search against a stream rotated by 3 bits.
      reset_check("rst_rotation");
      phase  = 3;
      pulses = 0;
      last_p = -1;
      c      = 0;
      while (c < 20000 && !locked) begin
         c++;
         drive(rotl(TOK0, phase), 1'b0, 2'b00, 8'h00);
         if (bitslip) begin
            pulses++;
            if (last_p >= 0) check("slip_period", c - last_p, SLIP_PERIOD);
            last_p = c;
            phase  = (phase + 1) % 10;
         end
      end
      check("rot_locked", {31'b0, locked}, 32'd1);
      check("rot_pulses", pulses, 32'd7);
      check("rot_lock_delay", c - last_p, 32'd13);
      drive(TOK0, 1'b0, 2'b00, 8'h00);
      drive(TOK0, 1'b0, 2'b00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the HDMI TMDS channel encoder: takes one raw 10-bit word per pixel clock from the channel deserializer.
- Finds word alignment by requesting bit slips until control tokens appear, then decodes each word back to 8-bit video data (VD), 2-bit control data (CD) and video-data-enable (VDE).
- One instance per colour channel (blue carries HSYNC/VSYNC on CD). Sits between the deserializer and the video timing recovery logic.

Parameters:
- LOCK_COUNT, 8: consecutive valid control tokens required to declare lock.
- SEARCH_TIMEOUT, 2048: cycles in SEARCH without reaching lock before a bit slip is requested.
- SLIP_SETTLE, 4: cycles to wait after a bitslip pulse before resuming search.
- LOSS_TIMEOUT, 4096: cycles in LOCKED with no control token before lock is dropped.

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- tmds_in  input  10  raw TMDS word from deserializer, bit 0 first on the wire.
- bitslip  output  1  one-cycle pulse asking the deserializer to shift alignment by one bit.
- locked  output  1  1 while the FSM is in LOCKED.
- VD  output  8  decoded video data.
- CD  output  2  decoded control data.
- VDE  output  1  1 = VD valid (data period), 0 = control period.

Behaviour:
- Reset (async, rst=1):
  - Outputs: bitslip=0, locked=0, VD=0, CD=0, VDE=0.
  - FSM enters SEARCH; all counters cleared.
  - Asserting rst mid-operation aborts any slip or lock immediately.
- Input stage: tmds_in is registered once (w). Decode is registered from w. Latency is 2 clk from tmds_in to VD/CD/VDE.
- Control tokens (exact match on w[9:0]):
  - 1101010100 -> CD=00
  - 0010101011 -> CD=01
  - 0101010100 -> CD=10
  - 1010101011 -> CD=11
  - is_ctrl = any match.
- Data decode, applied when not a token:
  - d = w[9] ? ~w[7:0] : w[7:0]
  - VD[0] = d[0]
  - for i = 1..7: VD[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Output rules:
  - If locked and is_ctrl: VDE=0, CD=token value, VD=0.
  - If locked and not is_ctrl: VDE=1, VD=decoded value, CD holds its last value.
  - If not locked: VDE=0, VD=0, CD=0.
  - Outputs use the lock state of the same cycle in which w is decoded.
- FSM states:
  - SEARCH:
    - ctrl_run counts consecutive is_ctrl cycles and clears on any non-token.
    - When ctrl_run reaches LOCK_COUNT-1 and is_ctrl is true -> LOCKED, with locked=1 from the next cycle.
    - search_cnt increments every cycle. At SEARCH_TIMEOUT-1 -> SLIP, with bitslip=1 for exactly the next cycle.
    - If lock and timeout occur on the same cycle, lock wins.
  - SLIP: single cycle with bitslip=1 -> SETTLE. Clears ctrl_run and search_cnt.
  - SETTLE: counts SLIP_SETTLE cycles ignoring input, then -> SEARCH with counters at 0.
  - LOCKED:
    - idle_cnt clears on each is_ctrl and increments otherwise.
    - When idle_cnt reaches LOSS_TIMEOUT-1 -> SEARCH, with locked=0 next cycle and outputs forced per the unlocked rule.
- Slipping wraps naturally: the deserializer cycles through 10 phases. The block only issues pulses and never tracks the phase.
- bitslip never asserts outside SLIP, and never on two consecutive cycles.
- Counter widths are $clog2(param)+1. No counter may wrap; each saturates at its threshold.
- No DC-balance state is needed for decoding; disparity errors are not checked.

Test Plan:
- Reset, then 8 consecutive 1101010100 words -> locked=1 on the cycle after the 8th word reaches w. No bitslip seen. CD=00, VDE=0 at output.
- After lock, drive tokens 0010101011, 0101010100, 1010101011 -> CD=01, 10, 11 with VDE=0, each 2 cycles after input.
- After lock, feed the encoder outputs for VD=0x00, 0xFF, 0x55, 0x10 (each at running disparity states 0, +, -) -> VD matches the source byte, VDE=1, latency 2. Sweep all 256 values through an encoder model.
- Feed the token stream rotated by 3 bits, with the bench model applying a rotation of one bit per bitslip -> bitslip pulses every SEARCH_TIMEOUT+1+SLIP_SETTLE cycles. Lock occurs after exactly 7 pulses (3+7 = 10) and the required LOCK_COUNT tokens.
- When locked, feed 4096 consecutive data words (no token) -> locked drops. VD/VDE forced to 0 and the search restarts. A token at count 4095 resets idle_cnt and keeps lock.
- Assert rst during the SETTLE state and during LOCKED -> all outputs 0 immediately (asynchronous). The FSM restarts in SEARCH on the first clock after release.
